// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS wave sequencer and its quarter-wave fold.
package dds_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int TBL_AW_DEF = 6;
  localparam int TBL_DW_DEF = 9;
  localparam int OUT_W_DEF  = TBL_DW_DEF + 1;
  localparam int PHASE_W    = 8;

  localparam logic [OUT_W_DEF-1:0] MIDSCALE = 10'h200;

  typedef enum logic [1:0] {
    SINE = 2'd0,
    TRI  = 2'd1,
    SQU  = 2'd2,
    OFF  = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/dds_quarter_fold.sv
// Combinational quarter-wave folding: phase index -> {table address, sign},
// and sign + quarter-table data -> full-period offset-binary sample.
module dds_quarter_fold #(
  parameter int TBL_AW = 6,
  parameter int TBL_DW = 9,
  parameter int OUT_W  = 10
) (
  input  logic [TBL_AW+1:0] phase_idx,
  output logic [TBL_AW-1:0] addr,
  output logic              neg,
  input  logic              rec_neg,
  input  logic [1:0]        rec_wave,
  input  logic [TBL_DW-1:0] rec_data,
  output logic [OUT_W-1:0]  sample
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  logic [1:0]        quad;
  logic [TBL_AW-1:0] idx;
  logic [OUT_W-1:0]  ext;

  always_comb begin
    quad = phase_idx[TBL_AW+1:TBL_AW];
    idx  = phase_idx[TBL_AW-1:0];
    // Odd quadrants run the table backwards; ~idx is (2^TBL_AW - 1) - idx.
    addr = quad[0] ? ~idx : idx;
    neg  = quad[1];
  end

  always_comb begin
    ext = OUT_W'(rec_data);
    if (rec_wave == 2'd3) begin
      sample = MID;
    end else if (rec_neg) begin
      sample = MID - OUT_W'(1) - ext;
    end else begin
      sample = MID + ext;
    end
  end

endmodule

// File: rtl/dds_wave_sequencer.sv
// Phase-accumulator sequencer: acc (n) -> table address/sign (n+1) -> DAC sample (n+2).
// New configs are accepted into a shadow while running and swapped in at the accumulator wrap.
module dds_wave_sequencer
  import dds_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int TBL_AW = 6,
  parameter int TBL_DW = 9,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [1:0]        cfg_wave,
  input  logic [7:0]        cfg_phase,
  output logic [1:0]        tbl_sel,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [TBL_DW-1:0] tbl_data,
  output logic [OUT_W-1:0]  dac_data,
  output logic              dac_valid,
  output logic              cycle_start
);

  localparam int PW = TBL_AW + 2;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  state_e            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W-1:0]  act_fword, act_fword_nxt, sh_fword, sh_fword_nxt;
  wave_e             act_wave, act_wave_nxt, sh_wave, sh_wave_nxt;
  logic [7:0]        act_phase, act_phase_nxt, sh_phase, sh_phase_nxt;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic              accept;
  logic              wrap_nxt;

  logic              wrap0, wrap1, vld1, sign1;
  logic [PW-1:0]     p_idx;
  logic [TBL_AW-1:0] fold_addr;
  logic              fold_neg;
  logic [OUT_W-1:0]  sample;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    act_fword_nxt = act_fword;
    act_wave_nxt  = act_wave;
    act_phase_nxt = act_phase;
    sh_fword_nxt  = sh_fword;
    sh_wave_nxt   = sh_wave;
    sh_phase_nxt  = sh_phase;
    wrap_nxt      = 1'b0;
    cfg_ready     = (state != S_PEND);
    accept        = cfg_valid && cfg_ready;
    sum           = {1'b0, acc} + {1'b0, act_fword};
    carry         = sum[ACC_W];

    if (!en) begin
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      // Leaving run mode promotes whatever config is waiting, so nothing is lost.
      if (state == S_PEND) begin
        act_fword_nxt = sh_fword;
        act_wave_nxt  = sh_wave;
        act_phase_nxt = sh_phase;
      end else if (accept) begin
        act_fword_nxt = cfg_fword;
        act_wave_nxt  = wave_e'(cfg_wave);
        act_phase_nxt = cfg_phase;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_RUN;
          if (accept) begin
            act_fword_nxt = cfg_fword;
            act_wave_nxt  = wave_e'(cfg_wave);
            act_phase_nxt = cfg_phase;
          end
        end
        S_RUN: begin
          acc_nxt  = sum[ACC_W-1:0];
          wrap_nxt = carry;
          if (accept) begin
            sh_fword_nxt = cfg_fword;
            sh_wave_nxt  = wave_e'(cfg_wave);
            sh_phase_nxt = cfg_phase;
            state_nxt    = S_PEND;
          end
        end
        S_PEND: begin
          acc_nxt  = sum[ACC_W-1:0];
          wrap_nxt = carry;
          // A zero tuning word never wraps, so swap immediately instead of stalling forever.
          if (carry || (act_fword == '0)) begin
            act_fword_nxt = sh_fword;
            act_wave_nxt  = sh_wave;
            act_phase_nxt = sh_phase;
            state_nxt     = S_RUN;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      act_fword <= '0;
      act_wave  <= OFF;
      act_phase <= '0;
      sh_fword  <= '0;
      sh_wave   <= OFF;
      sh_phase  <= '0;
      wrap0     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      act_fword <= act_fword_nxt;
      act_wave  <= act_wave_nxt;
      act_phase <= act_phase_nxt;
      sh_fword  <= sh_fword_nxt;
      sh_wave   <= sh_wave_nxt;
      sh_phase  <= sh_phase_nxt;
      wrap0     <= wrap_nxt;
    end
  end

  assign p_idx = acc[ACC_W-1 -: PW] + PW'(act_phase);

  dds_quarter_fold #(
    .TBL_AW(TBL_AW),
    .TBL_DW(TBL_DW),
    .OUT_W (OUT_W)
  ) u_fold (
    .phase_idx(p_idx),
    .addr     (fold_addr),
    .neg      (fold_neg),
    .rec_neg  (sign1),
    .rec_wave (tbl_sel),
    .rec_data (tbl_data),
    .sample   (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_addr <= '0;
      tbl_sel  <= 2'd3;
      sign1    <= 1'b0;
      vld1     <= 1'b0;
      wrap1    <= 1'b0;
    end else begin
      tbl_addr <= fold_addr;
      tbl_sel  <= act_wave;
      sign1    <= fold_neg;
      vld1     <= en && (state != S_IDLE);
      wrap1    <= en && wrap0;
    end
  end

  // Dropping en kills the in-flight sample right away and parks the DAC at midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data    <= MID;
      dac_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else if (!en) begin
      dac_data    <= MID;
      dac_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      dac_data    <= vld1 ? sample : MID;
      dac_valid   <= vld1;
      cycle_start <= vld1 && wrap1;
    end
  end

endmodule
